mul_burst_accumulator: RTL
==========================

Name: mul_burst_accumulator

Overview:
- Downstream consumer of the combinational 3x4 partial-product multiplier.
- Takes a stream of 7-bit products over a valid/ready handshake and sums BURST consecutive products into a saturating accumulator.
- Presents each completed sum on a registered valid/ready output port for the next stage.
- This is the first registered stage after the multiplier array. It provides backpressure to the operand source.

Parameters:
- PROD_W, 7: product input width (3-bit x 4-bit unsigned product).
- ACC_W, 10: accumulator/output width. Must be >= PROD_W.
- BURST, 4: products summed per output result. Must be >= 1.
- CNT_W, 2: beat counter width. Must be >= max(1, clog2(BURST)).

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a product beat.
- prod  in  PROD_W  unsigned product from the multiplier.
- clear  in  1  synchronous abort: discard partial/held result.
- out_valid  out  1  acc_out holds a completed burst sum.
- out_ready  in  1  downstream accepts the result.
- acc_out  out  ACC_W  burst sum, saturated.
- sat  out  1  saturation occurred during this burst (sticky per burst).
- beat_cnt  out  CNT_W  beats accepted in the current burst.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = ACC.
  - acc_out = 0, sat = 0, beat_cnt = 0, out_valid = 0, in_ready = 1 (after reset).
- States: ACC (collecting) and HOLD (result presented).
- in_ready = 1 in ACC, 0 in HOLD. It is decoded from registered state, with no combinational path from in_valid or out_ready.
- out_valid = 1 exactly in HOLD.
- Accept (ACC): a beat transfers when in_valid & in_ready at a rising edge.
  - Sum rule: next = acc_out + zero-extended prod, computed at ACC_W+1 bits.
  - If next > 2^ACC_W - 1, then acc_out = 2^ACC_W - 1 and sat = 1. Otherwise acc_out = next.
  - Once saturated, acc_out stays all-ones for the rest of the burst.
- Beat counting:
  - A non-final beat increments beat_cnt.
  - On the final beat (beat_cnt == BURST-1): the accumulate happens, beat_cnt returns to 0, and the state goes to HOLD.
- Latency: out_valid rises the cycle after the final beat is accepted, with acc_out already including that beat.
- HOLD:
  - acc_out and sat are stable.
  - On out_valid & out_ready: the state goes to ACC, and acc_out = 0, sat = 0 on the same edge.
  - The next beat can be accepted the following cycle, giving at most one bubble per burst.
- Backpressure: HOLD persists indefinitely while out_ready = 0. Upstream beats stall (in_ready = 0) and no data is lost.
- clear (synchronous, highest priority after reset):
  - In ACC: acc_out = 0, sat = 0, beat_cnt = 0. A beat handshaking in the same cycle is consumed and discarded.
  - In HOLD: the held result is dropped and the state goes to ACC with all registers zeroed, even if out_ready = 1 that cycle.
- in_valid in HOLD is ignored.
- out_ready in ACC is ignored.
- BURST = 1: every accepted beat goes directly to HOLD with acc_out = prod.
- Reset mid-burst or mid-HOLD: everything returns to reset values immediately and the partial sum is lost.
- No X propagation: prod is sampled only on an accept.

Test Plan:
- Default params, beats 3, 5, 7, 9 with out_ready = 1 -> out_valid high for exactly 1 cycle, the cycle after the 9 is accepted; acc_out = 24, sat = 0; in_ready low for that one cycle.
- Same burst with out_ready = 0 for 5 cycles -> HOLD for 5 cycles, acc_out = 24 stable, in_ready = 0; a 5th beat presented is not lost and is accepted after release as beat 0 of the next burst.
- ACC_W = 8, beats 105 x 4 -> acc_out = 255, sat = 1. After hand-off the next burst 1, 1, 1, 1 gives acc_out = 4, sat = 0.
- Beats 10, 20, then clear on the 3rd beat (prod = 30, in_valid = 1) -> beat_cnt = 0, acc_out = 0. Then 1, 2, 3, 4 gives acc_out = 10.
- Drive rst_n low mid-HOLD (acc_out = 24), asynchronously between edges -> outputs reset immediately, out_valid = 0, in_ready = 1 after release.
- BURST = 1, CNT_W = 1, back-to-back beats 7, 8 with out_ready = 1 -> results 7 then 8 on alternate cycles, in_ready toggling 1/0.

Source files
------------

// File: rtl/mul_burst_accumulator.sv
// Purpose: sums BURST consecutive multiplier products into a saturating accumulator and presents each burst sum downstream.
// Latency: out_valid rises the cycle after the final beat of a burst is accepted; acc_out already includes that beat.
// Backpressure: in_ready drops while a result is held; the hold lasts as long as out_ready stays low, and no beat is lost.
module mul_burst_accumulator #(
    parameter int PROD_W = 7,   // product width (3-bit x 4-bit unsigned)
    parameter int ACC_W  = 10,  // accumulator width, must be >= PROD_W
    parameter int BURST  = 4,   // products per result, must be >= 1
    parameter int CNT_W  = 2    // beat counter width, >= max(1, clog2(BURST))
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              sat,
    output logic [CNT_W-1:0]  beat_cnt
);

    // ACC collects beats; HOLD presents a finished sum until it is taken.
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
    localparam logic [ACC_W-1:0] ACC_MAX   = '1;
    localparam int               EXT_W     = ACC_W + 1 - PROD_W;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic               sat_q;
    logic               sat_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W:0]     sum_w;
    logic               last_beat;

    // The final beat is recognised from the registered count, so BURST=1
    // sends every beat straight to HOLD.
    assign last_beat = (cnt_q == LAST_BEAT);

    // Candidate accumulate result: one guard bit catches overflow, which
    // clamps to all-ones. Once all-ones, any further add overflows or adds
    // zero, so the clamp is naturally sticky for the rest of the burst.
    // prod only reaches state through the accept branch below.
    always_comb begin
        sum_w = {1'b0, acc_q} + {{EXT_W{1'b0}}, prod};
        acc_d = sum_w[ACC_W-1:0];
        sat_d = sat_q;
        if (sum_w[ACC_W]) begin
            acc_d = ACC_MAX;
            sat_d = 1'b1;
        end
    end

    // Burst FSM with its datapath registers; clear overrides everything but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (clear) begin
            // Abort: any partial or held result is dropped, including a beat
            // that happens to handshake this cycle.
            state_q <= ST_ACC;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        sat_q <= sat_d;
                        if (last_beat) begin
                            cnt_q   <= '0;
                            state_q <= ST_HOLD;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Result leaves and the accumulator restarts on the same edge,
                    // so the only bubble per burst is the hold cycle itself.
                    if (out_ready) begin
                        state_q <= ST_ACC;
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_ACC;
                end
            endcase
        end
    end

    // Handshake outputs are pure decodes of registered state: no path from
    // in_valid or out_ready to in_ready or out_valid.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign acc_out   = acc_q;
    assign sat       = sat_q;
    assign beat_cnt  = cnt_q;

endmodule
